pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register for the pipelined CPU. It carries a PC+4 / instruction pair between adjacent stages, with the first use at IF/ID. It replaces the plain enable-and-clear register pair with a valid/ready handshake, a one-entry skid buffer for full throughput under back-pressure, and a synchronous flush that injects a NOP bubble. Optional stall/flush performance counters are compiled in by macro.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default field widths, the NOP bubble value and the
// packed beat type held by every flow-controlled stage register.
package pipe_pkg;

    localparam int unsigned PIPE_PC_W   = 32;
    localparam int unsigned PIPE_INST_W = 32;

    localparam logic [PIPE_INST_W-1:0] PIPE_NOP_INST = 32'h0000_0000;

    // One beat travelling between adjacent stages (main and skid entries alike).
    typedef struct packed {
        logic [PIPE_PC_W-1:0]   pc_plus4;
        logic [PIPE_INST_W-1:0] inst;
    } stage_beat_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stage performance statistics.
// Only present when PIPE_STAGE_PERF_EN is defined; it has no users otherwise.
`ifdef PIPE_STAGE_PERF_EN
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment on request, sticking at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register (PC+4 / instruction pair) with a
// one-entry skid buffer and a synchronous flush that leaves a NOP bubble.
// Optional stall/flush counters are built when PIPE_STAGE_PERF_EN is defined.
// Beat storage uses the package field widths; ports are cast to and from them.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       PC_W     = PIPE_PC_W,
    parameter int unsigned       INST_W   = PIPE_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST)
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned       CNT_W    = 16
`endif
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc_plus4,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc_plus4,
    output logic [INST_W-1:0] out_inst
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [PIPE_INST_W-1:0] NOP_BEAT_INST = PIPE_INST_W'(NOP_INST);

    stage_beat_t m_q, m_d;
    stage_beat_t s_q, s_d;
    logic        m_valid_q, m_valid_d;
    logic        s_valid_q, s_valid_d;
    logic        in_ready_q, in_ready_d;

    stage_beat_t beat_in_c;
    logic        accept_c;
    logic        drain_c;

    assign beat_in_c.pc_plus4 = PIPE_PC_W'(in_pc_plus4);
    assign beat_in_c.inst     = PIPE_INST_W'(in_inst);

    assign accept_c = in_valid && in_ready_q;
    assign drain_c  = m_valid_q && out_ready;

    // Next-state: flush, then skid refill, then main load, then skid load, then drain.
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_d.inst  = NOP_BEAT_INST;
        end else if (drain_c && s_valid_q) begin
            m_d       = s_q;
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
        end else if (accept_c && (!m_valid_q || drain_c)) begin
            m_d       = beat_in_c;
            m_valid_d = 1'b1;
        end else if (accept_c) begin
            s_d       = beat_in_c;
            s_valid_d = 1'b1;
        end else if (drain_c) begin
            m_valid_d = 1'b0;
            m_d.inst  = NOP_BEAT_INST;
        end

        // Registered so that in_ready never depends combinationally on out_ready.
        in_ready_d = !s_valid_d;
    end

    // Stage state registers.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            m_q.pc_plus4 <= '0;
            m_q.inst     <= NOP_BEAT_INST;
            s_q          <= '0;
            m_valid_q    <= 1'b0;
            s_valid_q    <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            m_q          <= m_d;
            s_q          <= s_d;
            m_valid_q    <= m_valid_d;
            s_valid_q    <= s_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = m_valid_q;
    assign out_pc_plus4 = PC_W'(m_q.pc_plus4);
    assign out_inst     = INST_W'(m_q.inst);

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc_c;
    logic flush_inc_c;

    // A flush counts only when it kills a held beat or one arriving this cycle.
    assign stall_inc_c = m_valid_q && !out_ready;
    assign flush_inc_c = flush && (m_valid_q || s_valid_q || accept_c);

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (Clk),
        .rst_n  (Clrn),
        .inc_en (stall_inc_c),
        .count  (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (Clk),
        .rst_n  (Clrn),
        .inc_en (flush_inc_c),
        .count  (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted beats are queued, drained beats
// are popped and compared; directed checks cover reset, stall, flush and async reset.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_inst;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    stage_beat_t exp_q[$];

    pipe_stage_reg dut (
        .Clk          (Clk),
        .Clrn         (Clrn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc_plus4  (in_pc_plus4),
        .in_inst      (in_inst),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc_plus4 (out_pc_plus4),
        .out_inst     (out_inst)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid    = v;
        in_pc_plus4 = pc;
        in_inst     = 32'hA000_0000 | pc;
    endtask

    // Monitor: compare drained beats, check bubbles, and record accepted beats.
    always @(negedge Clk) begin
        if (Clrn) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got pc 0x%0h, expected none", out_pc_plus4);
                end else begin
                    stage_beat_t e;
                    e = exp_q.pop_front();
                    check("drain_beat", {out_pc_plus4, out_inst}, {e.pc_plus4, e.inst});
                end
            end
            if (!out_valid) check("bubble_nop", 64'(out_inst), 64'h0);
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back('{pc_plus4: in_pc_plus4, inst: in_inst});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        Clrn      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0);

        // Reset values
        #12;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_out_inst", 64'(out_inst), 64'h0);
        check("rst_out_pc", 64'(out_pc_plus4), 64'h0);
`ifdef PIPE_STAGE_PERF_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'h0);
`endif
        @(negedge Clk);
        Clrn = 1'b1;
        tick();

        // Streaming at full rate: each beat visible one cycle after it is sent
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'(4 * i));
            tick();
            check("stream_in_ready", 64'(in_ready), 64'h1);
            check("stream_out_valid", 64'(out_valid), 64'h1);
            check("stream_out_pc", 64'(out_pc_plus4), 64'(4 * i));
        end
        drive(1'b0, 32'h0);
        tick();
        check("stream_empty", 64'(out_valid), 64'h0);

        // Back-pressure: 0x4 in main, 0x8 in skid, 0xC refused
        out_ready = 1'b0;
        drive(1'b1, 32'h4);
        tick();
        drive(1'b1, 32'h8);
        tick();
        check("bp_out_pc", 64'(out_pc_plus4), 64'h4);
        check("bp_out_inst", 64'(out_inst), 64'hA000_0004);
        check("bp_in_ready", 64'(in_ready), 64'h0);
        drive(1'b1, 32'hC);
        tick();
        check("bp_hold_pc", 64'(out_pc_plus4), 64'h4);
        check("bp_hold_in_ready", 64'(in_ready), 64'h0);
        drive(1'b0, 32'h0);
        out_ready = 1'b1;
        tick();
        check("bp_skid_pc", 64'(out_pc_plus4), 64'h8);
        check("bp_skid_in_ready", 64'(in_ready), 64'h1);
`ifdef PIPE_STAGE_PERF_EN
        check("bp_stall_cnt", 64'(stall_cnt), 64'h2);
`endif
        tick();
        check("bp_drained", 64'(out_valid), 64'h0);

        // Flush with skid full
        out_ready = 1'b0;
        drive(1'b1, 32'h10);
        tick();
        drive(1'b1, 32'h14);
        tick();
        drive(1'b0, 32'h0);
        check("fl_full_in_ready", 64'(in_ready), 64'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'h0);
        check("fl_out_inst", 64'(out_inst), 64'h0);
        check("fl_in_ready", 64'(in_ready), 64'h1);
        check("fl_pc_held", 64'(out_pc_plus4), 64'h10);
`ifdef PIPE_STAGE_PERF_EN
        check("fl_flush_cnt", 64'(flush_cnt), 64'h1);
`endif

        // Flush with simultaneous accept discards the incoming beat
        out_ready = 1'b1;
        drive(1'b1, 32'h20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_acc_out_valid", 64'(out_valid), 64'h0);
        drive(1'b1, 32'h24);
        tick();
        check("fl_recover_pc", 64'(out_pc_plus4), 64'h24);
        drive(1'b0, 32'h0);
        tick();

        // Async reset mid-stall with the skid full
        out_ready = 1'b0;
        drive(1'b1, 32'h30);
        tick();
        drive(1'b1, 32'h34);
        tick();
        drive(1'b0, 32'h0);
        check("ar_pre_in_ready", 64'(in_ready), 64'h0);
        #2;
        Clrn = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'h0);
        check("ar_in_ready", 64'(in_ready), 64'h1);
        check("ar_out_pc", 64'(out_pc_plus4), 64'h0);
        check("ar_out_inst", 64'(out_inst), 64'h0);
`ifdef PIPE_STAGE_PERF_EN
        check("ar_stall_cnt", 64'(stall_cnt), 64'h0);
        check("ar_flush_cnt", 64'(flush_cnt), 64'h0);
`endif
        exp_q.delete();
        Clrn = 1'b1;
        out_ready = 1'b1;
        tick();
        drive(1'b1, 32'h40);
        tick();
        check("ar_recover_pc", 64'(out_pc_plus4), 64'h40);
        drive(1'b0, 32'h0);
        repeat (3) tick();
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
